nexthop_lookup_pipe: RTL and testbench

Parametrised, pipelined successor to the static next-hop selector in the NoC router front end. For each of NUM_INPUTS channels it takes a destination address and produces a one-hot next-hop vector for that destination (the directory-resolved destination). It also produces a one-hot vector for the channel's home memory controller, chosen by address interleaving across NUM_MEM controllers. Routes live in a runtime-programmable match/mask table instead of elaboration-time constants. Each channel has a valid/ready handshake, a registered output and saturating miss counters.

---
 rtl/nexthop_lookup_pipe.sv | 154 +++++++++++++++
 tb/tb_nexthop_lookup_pipe.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/nexthop_lookup_pipe.sv
// Per-channel next-hop lookup against a programmable match/mask table, with a
// one-deep registered result stage, home memory controller lookup and miss counters.
module nexthop_lookup_pipe #(
  parameter int          NUM_INPUTS = 4,
  parameter int          DEST_W     = 8,
  parameter int          NHOP_W     = 5,
  parameter int          NUM_MEM    = 2,
  parameter int unsigned MEM_BASE   = 32'hF0,
  parameter int          CNT_W      = 16,
  localparam int         NUM_ENTRIES = NUM_INPUTS * NHOP_W,
  localparam int         IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_INPUTS-1:0]          in_valid,
  output logic [NUM_INPUTS-1:0]          in_ready,
  input  logic [NUM_INPUTS*DEST_W-1:0]   in_dest,
  output logic [NUM_INPUTS-1:0]          out_valid,
  input  logic [NUM_INPUTS-1:0]          out_ready,
  output logic [NUM_INPUTS*NHOP_W-1:0]   out_nhop,
  output logic [NUM_INPUTS*NHOP_W-1:0]   out_mem_nhop,
  output logic [NUM_INPUTS-1:0]          out_miss,
  output logic [NUM_INPUTS-1:0]          out_mem_miss,
  input  logic                           cfg_we,
  input  logic [IDX_W-1:0]               cfg_idx,
  input  logic                           cfg_en,
  input  logic [DEST_W-1:0]              cfg_value,
  input  logic [DEST_W-1:0]              cfg_mask,
  output logic [NUM_INPUTS*CNT_W-1:0]    miss_cnt,
  input  logic                           miss_clr
);

  localparam logic [DEST_W-1:0] MEM_BASE_W = DEST_W'(MEM_BASE);
  // NUM_MEM is a power of two, so the modulo reduces to a low-bit mask.
  localparam logic [DEST_W-1:0] MEM_SEL    = DEST_W'(NUM_MEM - 1);

  logic                tbl_en_q   [NUM_ENTRIES];
  logic                tbl_en_d   [NUM_ENTRIES];
  logic [DEST_W-1:0]   tbl_val_q  [NUM_ENTRIES];
  logic [DEST_W-1:0]   tbl_val_d  [NUM_ENTRIES];
  logic [DEST_W-1:0]   tbl_mask_q [NUM_ENTRIES];
  logic [DEST_W-1:0]   tbl_mask_d [NUM_ENTRIES];

  logic [NUM_INPUTS-1:0]        out_valid_q, out_valid_d;
  logic [NUM_INPUTS*NHOP_W-1:0] nhop_q, nhop_d;
  logic [NUM_INPUTS*NHOP_W-1:0] mem_nhop_q, mem_nhop_d;
  logic [NUM_INPUTS-1:0]        miss_q, miss_d;
  logic [NUM_INPUTS-1:0]        mem_miss_q, mem_miss_d;
  logic [NUM_INPUTS*CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

  logic [NUM_INPUTS*NHOP_W-1:0] look_nhop, look_mem;
  logic [NUM_INPUTS-1:0]        accept;
  logic [DEST_W-1:0]            dest, mem_addr;
  logic [CNT_W-1:0]             cnt;

  assign in_ready = ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;

  always_comb begin
    tbl_en_d   = tbl_en_q;
    tbl_val_d  = tbl_val_q;
    tbl_mask_d = tbl_mask_q;
    if (cfg_we && (int'(cfg_idx) < NUM_ENTRIES)) begin
      tbl_en_d[cfg_idx]   = cfg_en;
      tbl_val_d[cfg_idx]  = cfg_value;
      tbl_mask_d[cfg_idx] = cfg_mask;
    end
  end

  // Walk from the highest hop down so the lowest matching index is written last.
  always_comb begin
    look_nhop = '0;
    look_mem  = '0;
    dest      = '0;
    mem_addr  = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      dest     = in_dest[i*DEST_W +: DEST_W];
      mem_addr = MEM_BASE_W + (dest & MEM_SEL);
      for (int j = NHOP_W - 1; j >= 0; j--) begin
        if (tbl_en_q[i*NHOP_W+j] &&
            ((dest & tbl_mask_q[i*NHOP_W+j]) == (tbl_val_q[i*NHOP_W+j] & tbl_mask_q[i*NHOP_W+j]))) begin
          look_nhop[i*NHOP_W +: NHOP_W] = '0;
          look_nhop[i*NHOP_W + j]       = 1'b1;
        end
        if (tbl_en_q[i*NHOP_W+j] &&
            ((mem_addr & tbl_mask_q[i*NHOP_W+j]) == (tbl_val_q[i*NHOP_W+j] & tbl_mask_q[i*NHOP_W+j]))) begin
          look_mem[i*NHOP_W +: NHOP_W] = '0;
          look_mem[i*NHOP_W + j]       = 1'b1;
        end
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    nhop_d      = nhop_q;
    mem_nhop_d  = mem_nhop_q;
    miss_d      = miss_q;
    mem_miss_d  = mem_miss_q;
    miss_cnt_d  = miss_cnt_q;
    cnt         = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (accept[i]) begin
        out_valid_d[i]                 = 1'b1;
        nhop_d[i*NHOP_W +: NHOP_W]     = look_nhop[i*NHOP_W +: NHOP_W];
        mem_nhop_d[i*NHOP_W +: NHOP_W] = look_mem[i*NHOP_W +: NHOP_W];
        miss_d[i]                      = ~|look_nhop[i*NHOP_W +: NHOP_W];
        mem_miss_d[i]                  = ~|look_mem[i*NHOP_W +: NHOP_W];
      end else if (out_ready[i]) begin
        out_valid_d[i] = 1'b0;
      end
      cnt = miss_cnt_q[i*CNT_W +: CNT_W];
      if (miss_clr) begin
        miss_cnt_d[i*CNT_W +: CNT_W] = '0;
      end else if (accept[i] && ~|look_nhop[i*NHOP_W +: NHOP_W] && (cnt != '1)) begin
        miss_cnt_d[i*CNT_W +: CNT_W] = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        tbl_en_q[e]   <= 1'b0;
        tbl_val_q[e]  <= '0;
        tbl_mask_q[e] <= '0;
      end
      out_valid_q <= '0;
      nhop_q      <= '0;
      mem_nhop_q  <= '0;
      miss_q      <= '0;
      mem_miss_q  <= '0;
      miss_cnt_q  <= '0;
    end else begin
      tbl_en_q    <= tbl_en_d;
      tbl_val_q   <= tbl_val_d;
      tbl_mask_q  <= tbl_mask_d;
      out_valid_q <= out_valid_d;
      nhop_q      <= nhop_d;
      mem_nhop_q  <= mem_nhop_d;
      miss_q      <= miss_d;
      mem_miss_q  <= mem_miss_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_nhop     = nhop_q;
  assign out_mem_nhop = mem_nhop_q;
  assign out_miss     = miss_q;
  assign out_mem_miss = mem_miss_q;
  assign miss_cnt     = miss_cnt_q;

endmodule

// File: tb/tb_nexthop_lookup_pipe.sv
// Directed and randomized bench for nexthop_lookup_pipe against a table-level
// reference model; CNT_W is shrunk to 4 so counter saturation is reachable.
module tb_nexthop_lookup_pipe;

  localparam int NI = 4;
  localparam int DW = 8;
  localparam int NW = 5;
  localparam int NM = 2;
  localparam int MB = 'hF0;
  localparam int CW = 4;
  localparam int NE = NI * NW;
  localparam int IW = $clog2(NE);

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NI-1:0]     in_valid, in_ready, out_valid, out_ready, out_miss, out_mem_miss;
  logic [NI*DW-1:0]  in_dest;
  logic [NI*NW-1:0]  out_nhop, out_mem_nhop;
  logic              cfg_we, cfg_en, miss_clr;
  logic [IW-1:0]     cfg_idx;
  logic [DW-1:0]     cfg_value, cfg_mask;
  logic [NI*CW-1:0]  miss_cnt;

  nexthop_lookup_pipe #(
    .NUM_INPUTS(NI), .DEST_W(DW), .NHOP_W(NW), .NUM_MEM(NM), .MEM_BASE(MB), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_dest(in_dest),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_nhop(out_nhop), .out_mem_nhop(out_mem_nhop),
    .out_miss(out_miss), .out_mem_miss(out_mem_miss),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
    .cfg_value(cfg_value), .cfg_mask(cfg_mask),
    .miss_cnt(miss_cnt), .miss_clr(miss_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // stimulus for the next clock edge
  logic [NI-1:0]    s_in_valid, s_out_ready;
  logic [NI*DW-1:0] s_in_dest;
  logic             s_cfg_we, s_cfg_en, s_miss_clr;
  int               s_cfg_idx;
  logic [DW-1:0]    s_cfg_value, s_cfg_mask;

  // reference model state
  bit            m_en   [NE];
  logic [DW-1:0] m_val  [NE];
  logic [DW-1:0] m_mask [NE];
  bit            m_valid [NI];
  logic [NW-1:0] m_nhop  [NI];
  logic [NW-1:0] m_mem   [NI];
  int            m_cnt   [NI];

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [NW-1:0] refLookup(input int ch, input int addr);
    for (int j = 0; j < NW; j++) begin
      int e = ch * NW + j;
      if (m_en[e] && ((addr & int'(m_mask[e])) == (int'(m_val[e]) & int'(m_mask[e]))))
        return NW'(1 << j);
    end
    return '0;
  endfunction

  function automatic void resetModel();
    for (int e = 0; e < NE; e++) begin
      m_en[e] = 0; m_val[e] = '0; m_mask[e] = '0;
    end
    for (int i = 0; i < NI; i++) begin
      m_valid[i] = 0; m_nhop[i] = '0; m_mem[i] = '0; m_cnt[i] = 0;
    end
  endfunction

  function automatic void idleStim();
    s_in_valid = '0; s_out_ready = '1; s_in_dest = '0;
    s_cfg_we = 0; s_cfg_en = 0; s_cfg_idx = 0; s_cfg_value = '0; s_cfg_mask = '0;
    s_miss_clr = 0;
  endfunction

  function automatic void setCfg(input int idx, input bit en, input logic [DW-1:0] v, input logic [DW-1:0] m);
    s_cfg_we = 1; s_cfg_idx = idx; s_cfg_en = en; s_cfg_value = v; s_cfg_mask = m;
  endfunction

  function automatic void setReq(input int ch, input logic [DW-1:0] d);
    s_in_valid[ch] = 1'b1;
    s_in_dest[ch*DW +: DW] = d;
  endfunction

  task automatic checkState();
    for (int i = 0; i < NI; i++) begin
      checkOutput($sformatf("out_valid ch%0d", i), 64'(out_valid[i]), 64'(m_valid[i]));
      if (m_valid[i]) begin
        checkOutput($sformatf("out_nhop ch%0d", i), 64'(out_nhop[i*NW +: NW]), 64'(m_nhop[i]));
        checkOutput($sformatf("out_mem_nhop ch%0d", i), 64'(out_mem_nhop[i*NW +: NW]), 64'(m_mem[i]));
        checkOutput($sformatf("out_miss ch%0d", i), 64'(out_miss[i]), 64'(m_nhop[i] == '0));
        checkOutput($sformatf("out_mem_miss ch%0d", i), 64'(out_mem_miss[i]), 64'(m_mem[i] == '0));
      end
      checkOutput($sformatf("miss_cnt ch%0d", i), 64'(miss_cnt[i*CW +: CW]), 64'(m_cnt[i]));
    end
  endtask

  // Drive one cycle of stimulus at a negedge, predict the edge, check at the next negedge.
  task automatic applyStimulus();
    bit acc;
    logic [NW-1:0] hit, mhit;
    int d;
    in_valid = s_in_valid; out_ready = s_out_ready; in_dest = s_in_dest;
    cfg_we = s_cfg_we; cfg_idx = IW'(s_cfg_idx); cfg_en = s_cfg_en;
    cfg_value = s_cfg_value; cfg_mask = s_cfg_mask; miss_clr = s_miss_clr;
    #1;
    for (int i = 0; i < NI; i++) begin
      checkOutput($sformatf("in_ready ch%0d", i), 64'(in_ready[i]), 64'(!m_valid[i] || s_out_ready[i]));
      acc = s_in_valid[i] && (!m_valid[i] || s_out_ready[i]);
      d = int'(s_in_dest[i*DW +: DW]);
      hit  = refLookup(i, d);
      mhit = refLookup(i, (MB + (d % NM)) % 256);
      if (acc) begin
        m_valid[i] = 1; m_nhop[i] = hit; m_mem[i] = mhit;
      end else if (s_out_ready[i]) begin
        m_valid[i] = 0;
      end
      if (s_miss_clr) m_cnt[i] = 0;
      else if (acc && hit == '0 && m_cnt[i] < (1 << CW) - 1) m_cnt[i]++;
    end
    if (s_cfg_we && s_cfg_idx < NE) begin
      m_en[s_cfg_idx] = s_cfg_en; m_val[s_cfg_idx] = s_cfg_value; m_mask[s_cfg_idx] = s_cfg_mask;
    end
    @(negedge clk);
    checkState();
  endtask

  initial begin
    rst_n = 1'b0;
    idleStim();
    in_valid = '0; out_ready = '1; in_dest = '0;
    cfg_we = 0; cfg_idx = '0; cfg_en = 0; cfg_value = '0; cfg_mask = '0; miss_clr = 0;
    resetModel();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checkOutput("reset out_valid", 64'(out_valid), 64'(0));
    checkOutput("reset out_nhop", 64'(out_nhop), 64'(0));
    checkOutput("reset out_miss", 64'(out_miss), 64'(0));
    checkOutput("reset in_ready", 64'(in_ready), 64'(4'hF));
    checkOutput("reset miss_cnt", 64'(miss_cnt), 64'(0));

    // single match
    idleStim(); setCfg(2, 1, 8'h10, 8'hF0); applyStimulus();
    idleStim(); setReq(0, 8'h13); applyStimulus();
    checkOutput("tp1 nhop", 64'(out_nhop[4:0]), 64'(5'b00100));
    checkOutput("tp1 miss", 64'(out_miss[0]), 64'(0));

    // lowest index wins, then a miss
    idleStim(); setCfg(1, 1, 8'h13, 8'hFF); applyStimulus();
    idleStim(); setCfg(3, 1, 8'h13, 8'hFF); applyStimulus();
    idleStim(); setReq(0, 8'h13); applyStimulus();
    checkOutput("tp2 priority", 64'(out_nhop[4:0]), 64'(5'b00010));
    idleStim(); setReq(0, 8'h44); applyStimulus();
    checkOutput("tp2 miss", 64'(out_miss[0]), 64'(1));
    checkOutput("tp2 miss_cnt", 64'(miss_cnt[3:0]), 64'(1));

    // memory controller interleave on ch1
    idleStim(); setCfg(9, 1, 8'hF1, 8'hFF); applyStimulus();
    idleStim(); setReq(1, 8'h07); applyStimulus();
    checkOutput("tp3 mem_nhop", 64'(out_mem_nhop[9:5]), 64'(5'b10000));
    idleStim(); setReq(1, 8'h06); applyStimulus();
    checkOutput("tp3 mem_miss", 64'(out_mem_miss[1]), 64'(1));

    // ch0 stalled for three cycles while ch2 streams
    idleStim(); setReq(0, 8'h13); setReq(2, 8'h20); applyStimulus();
    for (int k = 0; k < 3; k++) begin
      idleStim(); s_out_ready[0] = 1'b0; setReq(0, 8'h44); setReq(2, 8'(8'h21 + k)); applyStimulus();
      checkOutput("tp4 stall nhop", 64'(out_nhop[4:0]), 64'(5'b00010));
    end
    idleStim(); applyStimulus();

    // table write coincident with a lookup
    idleStim(); setCfg(0, 1, 8'h13, 8'hFF); setReq(0, 8'h13); applyStimulus();
    checkOutput("tp5 old table", 64'(out_nhop[4:0]), 64'(5'b00010));
    idleStim(); setReq(0, 8'h13); applyStimulus();
    checkOutput("tp5 new table", 64'(out_nhop[4:0]), 64'(5'b00001));

    // saturation then clear on ch3 (empty table)
    for (int k = 0; k < 17; k++) begin
      idleStim(); setReq(3, 8'(k)); applyStimulus();
    end
    checkOutput("tp6 saturate", 64'(miss_cnt[15:12]), 64'(15));
    idleStim(); setReq(3, 8'h55); s_miss_clr = 1; applyStimulus();
    checkOutput("tp6 clear wins", 64'(miss_cnt[15:12]), 64'(0));

    // randomized traffic, config writes (including out-of-range indices) and clears
    for (int n = 0; n < 600; n++) begin
      idleStim();
      s_in_valid = NI'($urandom);
      for (int i = 0; i < NI; i++) begin
        s_out_ready[i] = ($urandom_range(0, 3) != 0);
        s_in_dest[i*DW +: DW] = ($urandom_range(0, 1) == 1) ? 8'($urandom) : {4'h1, 4'($urandom)};
      end
      if ($urandom_range(0, 3) == 0)
        setCfg($urandom_range(0, 31), 1'($urandom_range(0, 3) != 0),
               ($urandom_range(0, 1) == 1) ? 8'($urandom) : {4'h1, 4'($urandom)},
               ($urandom_range(0, 1) == 1) ? 8'hF0 : 8'($urandom));
      s_miss_clr = ($urandom_range(0, 31) == 0);
      applyStimulus();
    end

    // async reset mid-stream
    idleStim();
    for (int i = 0; i < NI; i++) setReq(i, 8'h13);
    in_valid = s_in_valid; in_dest = s_in_dest; out_ready = '1;
    cfg_we = 0; miss_clr = 0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset out_valid", 64'(out_valid), 64'(0));
    checkOutput("async reset miss_cnt", 64'(miss_cnt), 64'(0));
    resetModel();
    @(negedge clk);
    rst_n = 1'b1;
    idleStim(); setReq(0, 8'h13); setReq(1, 8'hF1); applyStimulus();
    checkOutput("post reset table empty", 64'(out_nhop), 64'(0));
    checkOutput("post reset miss", 64'(out_miss[1:0]), 64'(2'b11));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
